// File: rtl/univ_burst_shift_reg_amisha.sv
// Universal N-bit shift register: hold, shift left/right and parallel load
// under manual control, plus an autonomous burst mode that shifts a programmed
// number of positions and pulses done when the burst completes.
module univ_burst_shift_reg_amisha #(
    parameter int N_amisha  = 8,
    parameter int LW_amisha = $clog2(N_amisha + 1) + 1
) (
    input  logic                 clk_amisha,
    input  logic                 reset_amisha,
    input  logic [1:0]           ctrl_amisha,
    input  logic [N_amisha-1:0]  d_amisha,
    input  logic                 s_in_lsb_amisha,
    input  logic                 s_in_msb_amisha,
    input  logic                 start_amisha,
    input  logic                 dir_amisha,
    input  logic [LW_amisha-1:0] len_amisha,
    output logic [N_amisha-1:0]  q_amisha,
    output logic                 s_out_msb_amisha,
    output logic                 s_out_lsb_amisha,
    output logic                 busy_amisha,
    output logic                 done_amisha
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        CTRL_HOLD  = 2'b00,
        CTRL_LEFT  = 2'b01,
        CTRL_RIGHT = 2'b10,
        CTRL_LOAD  = 2'b11
    } ctrl_t;

    state_t                 state, state_n;
    logic [LW_amisha-1:0]   cnt, cnt_n;
    logic                   dir_q, dir_n;
    logic [N_amisha-1:0]    q_r, q_n;
    logic                   done_r, done_n;
    logic [N_amisha-1:0]    q_shl, q_shr;

    // Candidate shift results; serial inputs are sampled live on every shift edge.
    always_comb begin
        q_shl = {q_r[N_amisha-2:0], s_in_lsb_amisha};
        q_shr = {s_in_msb_amisha, q_r[N_amisha-1:1]};
    end

    // State, counter, direction, data and done registers; reset wins over everything.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= 1'b0;
            q_r    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            dir_q  <= dir_n;
            q_r    <= q_n;
            done_r <= done_n;
        end
    end

    // Next-state logic: accept bursts or apply manual ops in IDLE, run the burst in SHIFT.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir_q;
        q_n     = q_r;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_amisha) begin
                    cnt_n = len_amisha;
                    dir_n = dir_amisha;
                    if (len_amisha == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    unique case (ctrl_t'(ctrl_amisha))
                        CTRL_HOLD:  q_n = q_r;
                        CTRL_LEFT:  q_n = q_shl;
                        CTRL_RIGHT: q_n = q_shr;
                        CTRL_LOAD:  q_n = d_amisha;
                        default:    q_n = q_r;
                    endcase
                end
            end
            SHIFT: begin
                q_n   = dir_q ? q_shr : q_shl;
                cnt_n = cnt - LW_amisha'(1);
                if (cnt == LW_amisha'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        q_amisha         = q_r;
        s_out_msb_amisha = q_r[N_amisha-1];
        s_out_lsb_amisha = q_r[0];
        busy_amisha      = (state == SHIFT);
        done_amisha      = done_r;
    end

endmodule

// File: tb/tb_univ_burst_shift_reg_amisha.sv
// Bench for univ_burst_shift_reg_amisha: directed scenarios followed by random
// stimulus, all compared against an arithmetic reference model.
module tb_univ_burst_shift_reg_amisha;

    localparam int N  = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ctrl;
    logic [N-1:0]  d;
    logic          s_lsb, s_msb, start, dir;
    logic [LW-1:0] len;
    logic [N-1:0]  q;
    logic          so_msb, so_lsb, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: word value as an integer and number of shifts still owed.
    int m_q   = 0;
    int m_rem = 0;
    bit m_dir = 0;
    bit m_done = 0;

    always #5 clk = ~clk;

    univ_burst_shift_reg_amisha #(.N_amisha(N), .LW_amisha(LW)) dut (
        .clk_amisha      (clk),
        .reset_amisha    (reset),
        .ctrl_amisha     (ctrl),
        .d_amisha        (d),
        .s_in_lsb_amisha (s_lsb),
        .s_in_msb_amisha (s_msb),
        .start_amisha    (start),
        .dir_amisha      (dir),
        .len_amisha      (len),
        .q_amisha        (q),
        .s_out_msb_amisha(so_msb),
        .s_out_lsb_amisha(so_lsb),
        .busy_amisha     (busy),
        .done_amisha     (done)
    );

    function automatic int shl(int v, bit b);
        return (v * 2 + int'(b)) % (2 ** N);
    endfunction

    function automatic int shr(int v, bit b);
        return v / 2 + int'(b) * (2 ** (N - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_q = 0; m_rem = 0; m_dir = 0; m_done = 0;
        end else if (m_rem > 0) begin
            m_q = m_dir ? shr(m_q, s_msb) : shl(m_q, s_lsb);
            m_rem--;
            m_done = (m_rem == 0);
        end else if (start) begin
            m_dir  = dir;
            m_rem  = int'(len);
            m_done = (len == 0);
        end else begin
            m_done = 0;
            case (ctrl)
                2'b01: m_q = shl(m_q, s_lsb);
                2'b10: m_q = shr(m_q, s_msb);
                2'b11: m_q = int'(d);
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        logic [31:0] eq;
        eq = 32'(m_q);
        chk("q", 32'(q), eq);
        chk("s_out_msb", 32'(so_msb), 32'(eq[N-1]));
        chk("s_out_lsb", 32'(so_lsb), 32'(eq[0]));
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_done));
    endtask

    // One clock edge: model follows the same sampled inputs, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    int busy_cnt, done_cnt;

    initial begin
        reset = 1; ctrl = 0; d = 0; s_lsb = 0; s_msb = 0; start = 0; dir = 0; len = 0;
        tick();
        reset = 0;

        // Reset clears a preloaded word.
        ctrl = 2'b11; d = 8'hFF; tick();
        chk("preload", 32'(q), 32'h0FF);
        ctrl = 2'b00; reset = 1; tick();
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 0;

        // Manual load, left and right shifts.
        ctrl = 2'b11; d = 8'hA5; tick();
        chk("load_a5", 32'(q), 32'hA5);
        ctrl = 2'b01; s_lsb = 1; tick();
        chk("shl_4b", 32'(q), 32'h4B);
        ctrl = 2'b10; s_msb = 0; tick();
        chk("shr_25", 32'(q), 32'h25);
        chk("shr_lsb", 32'(so_lsb), 32'h1);

        // Right burst of 3 with s_in_msb held high.
        ctrl = 2'b11; d = 8'h81; tick();
        ctrl = 2'b00; start = 1; dir = 1; len = 3; s_msb = 1; tick();
        chk("accept_q", 32'(q), 32'h81);
        start = 0; dir = 0; len = 0;
        tick(); chk("burst_c0", 32'(q), 32'hC0);
        tick(); chk("burst_e0", 32'(q), 32'hE0);
        tick(); chk("burst_f0", 32'(q), 32'hF0);
        chk("burst_done", 32'(done), 32'h1);
        chk("burst_busy_end", 32'(busy), 32'h0);
        tick(); chk("done_once", 32'(done), 32'h0);

        // Zero-length burst, then long left burst starting in the done cycle.
        ctrl = 2'b11; d = 8'h3C; tick();
        ctrl = 2'b00; start = 1; len = 0; tick();
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_busy", 32'(busy), 32'h0);
        chk("len0_q", 32'(q), 32'h3C);
        start = 1; len = 10; dir = 0; s_lsb = 0; tick();
        start = 0; busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            busy_cnt += int'(busy);
            tick();
            done_cnt += int'(done);
        end
        chk("len10_q", 32'(q), 32'h0);
        chk("len10_done", 32'(done), 32'h1);
        chk("len10_busy_cycles", 32'(busy_cnt), 32'd10);
        chk("len10_done_count", 32'(done_cnt), 32'd1);

        // Inputs ignored during a burst; start in the done cycle is accepted.
        ctrl = 2'b11; d = 8'h5A; tick();
        ctrl = 2'b00; start = 1; len = 4; dir = 0; s_lsb = 1; tick();
        ctrl = 2'b11; d = 8'hFF; len = 2; dir = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("ign_q", 32'(q), 32'hAF);
        chk("ign_done", 32'(done), 32'h1);
        tick();
        chk("restart_busy", 32'(busy), 32'h1);
        start = 0; ctrl = 2'b00;
        tick(); tick();

        // Reset mid-burst aborts with no done pulse.
        start = 1; len = 5; dir = 0; s_lsb = 1; tick();
        start = 0;
        tick(); tick();
        reset = 1; tick();
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        reset = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 60) == 0);
            ctrl  = 2'($urandom);
            d     = 8'($urandom);
            s_lsb = 1'($urandom);
            s_msb = 1'($urandom);
            start = ($urandom_range(0, 4) == 0);
            dir   = 1'($urandom);
            len   = 5'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(1, 31));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_burst_shift_reg_amisha.md
# univ_burst_shift_reg_amisha

Parametrised universal shift register: N-bit register with hold, left shift, right shift and parallel load, plus an autonomous burst mode that shifts a programmed number of positions and reports completion. It is the general-purpose serial/parallel converter for serial links, bit-banged peripherals and serialiser/deserialiser front ends.

## Interface
- N_amisha, 8, register width (N_amisha >= 2)
- LW_amisha, $clog2(N_amisha+1)+1, width of the burst length field (default 5 for N=8)

- clk_amisha  in  1  clock; all state changes on its rising edge
- reset_amisha  in  1  synchronous, active-high reset
- ctrl_amisha  in  2  manual mode: 00 hold, 01 shift left, 10 shift right, 11 parallel load
- d_amisha  in  N_amisha  parallel load data
- s_in_lsb_amisha  in  1  serial input entering bit 0 on a left shift
- s_in_msb_amisha  in  1  serial input entering bit N-1 on a right shift
- start_amisha  in  1  burst request, sampled only in IDLE
- dir_amisha  in  1  burst direction, latched at accept: 0 left, 1 right
- len_amisha  in  LW_amisha  number of shifts in the burst (0 allowed)
- q_amisha  out  N_amisha  register contents
- s_out_msb_amisha  out  1  q_amisha[N-1]
- s_out_lsb_amisha  out  1  q_amisha[0]
- busy_amisha  out  1  burst in progress (registered)
- done_amisha  out  1  one-cycle pulse after a burst completes (registered)

## Operation
- Left shift: q <= {q[N-2:0], s_in_lsb_amisha}. Right shift: q <= {s_in_msb_amisha, q[N-1:1]}.
- FSM states: IDLE, SHIFT. Internal down-counter cnt (LW_amisha bits), latched direction bit.
- IDLE, start_amisha=1: accept. cnt <= len_amisha, dir latched, q unchanged on this edge, ctrl_amisha ignored. If len_amisha=0: stay IDLE, done_amisha <= 1. Else go SHIFT.
- IDLE, start_amisha=0: apply ctrl_amisha.
- SHIFT: each edge shifts q once in latched direction, cnt <= cnt-1. On the edge with cnt=1: go IDLE, done_amisha <= 1.
- In SHIFT: ctrl_amisha, d_amisha, start_amisha, dir_amisha and len_amisha are ignored. Serial inputs are sampled live on every shift edge, so callers can stream bits.
- len_amisha > N_amisha is legal. The register simply shifts more than N positions, so the whole word is filled from the serial input.
- busy_amisha = (state == SHIFT). done_amisha is high only in the cycle immediately after the completing edge; otherwise 0.
- In the done cycle the state is IDLE, so a new start or a manual ctrl is honoured in that cycle.

## Timing
- Reset (synchronous, wins over everything): q_amisha=0, s_out_*=0, busy_amisha=0, done_amisha=0, state IDLE, cnt=0.
- Reset asserted mid-burst aborts the burst with no done pulse.
- Manual op: result is visible in q_amisha one cycle after the edge that samples ctrl_amisha.
- Burst of len L>0 accepted at edge E0:
  - busy_amisha is high from after E0 through the cycle containing edge E_L, exactly L cycles.
  - Shifts occur at edges E1..E_L.
  - done_amisha and the final q_amisha are both visible after E_L.
  - Total: L+1 edges from accept to done.
- Burst with len 0: done_amisha is high the cycle after accept, busy_amisha stays 0, q unchanged.
- s_out_* track q_amisha combinationally from the register, with no extra latency.

## Test plan
- Reset with q preloaded to 8'hFF -> after one edge q=8'h00, busy=0, done=0.
- N=8, ctrl=11, d=8'hA5; then ctrl=01, s_in_lsb=1 -> q=8'h4B; then ctrl=10, s_in_msb=0 -> q=8'h25, s_out_lsb=1.
- Load 8'h81; start with dir=1, len=3, s_in_msb held 1 -> q steps C0, E0, F0; busy high exactly 3 cycles; done pulses once; final q=8'hF0.
- Load 8'h3C; start with len=0 -> busy never rises, done high one cycle later, q stays 8'h3C. Then start with len=10, dir=0, s_in_lsb=0 -> q=8'h00 and done after 11 edges.
- During a len=4 burst, assert start and ctrl=11 with d=8'hFF -> both ignored and the burst completes normally. Start in the done cycle -> accepted.
- Reset after 2 of 5 shifts -> q=0, busy=0 next cycle, no done pulse ever appears.
